// File: rtl/alu_arbiter_if.sv
// Request, alu and response signals of the shared-alu arbiter.
// The arbiter uses the slave modport; requesters, alu and consumer sit on the master side.
interface alu_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [5*NUM_REQ-1:0]  req_op;
    logic [NUM_REQ-1:0]    req_sat;

    logic [31:0]           alu_a;
    logic [31:0]           alu_b;
    logic [4:0]            alu_op;
    logic                  alu_saturate;
    logic [31:0]           alu_result;
    logic [3:0]            alu_flags;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic [3:0]            rsp_flags;

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_sat,
        output req_ready,
        output alu_a, alu_b, alu_op, alu_saturate,
        input  alu_result, alu_flags,
        output rsp_valid, rsp_id, rsp_result, rsp_flags,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_op, req_sat,
        input  req_ready,
        input  alu_a, alu_b, alu_op, alu_saturate,
        output alu_result, alu_flags,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational alu, with a one-entry tagged response buffer.
// Optional macro ALU_ARB_STATS_EN adds saturating per-requester grant and stall counters.
module alu_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [16*NUM_REQ-1:0] stat_grants,
    output logic [15:0]           stat_stall
`endif
);

    logic                  rsp_valid_q;
    logic [ID_W-1:0]       rsp_id_q;
    logic [31:0]           rsp_result_q;
    logic [3:0]            rsp_flags_q;
    logic [ID_W-1:0]       rr_ptr_q;

    logic                  can_issue;
    logic                  grant_valid;
    logic [2*NUM_REQ-1:0]  req_dbl;
    logic [NUM_REQ-1:0]    req_rot;
    logic [ID_W-1:0]       offset;
    logic [ID_W:0]         win_sum;
    logic [ID_W:0]         nxt_sum;
    logic [ID_W-1:0]       winner;
    logic [ID_W-1:0]       next_ptr;

    always_comb begin
        can_issue = !rst && (!rsp_valid_q || bus.rsp_ready);
        // Rotate valids so rr_ptr lands on bit 0, then pick the lowest set bit.
        req_dbl     = {bus.req_valid, bus.req_valid} >> rr_ptr_q;
        req_rot     = req_dbl[NUM_REQ-1:0];
        grant_valid = can_issue && (|req_rot);
        offset      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) offset = ID_W'(i);
        end
        win_sum = {1'b0, rr_ptr_q} + {1'b0, offset};
        if (win_sum >= (ID_W+1)'(NUM_REQ)) win_sum = win_sum - (ID_W+1)'(NUM_REQ);
        winner  = win_sum[ID_W-1:0];
        nxt_sum = {1'b0, winner} + (ID_W+1)'(1);
        if (nxt_sum >= (ID_W+1)'(NUM_REQ)) nxt_sum = '0;
        next_ptr = nxt_sum[ID_W-1:0];
    end

    assign bus.req_ready    = grant_valid ? (NUM_REQ'(1) << winner) : '0;
    // Idle alu inputs are held at ADD 0,0.
    assign bus.alu_a        = grant_valid ? bus.req_a[32*winner +: 32] : '0;
    assign bus.alu_b        = grant_valid ? bus.req_b[32*winner +: 32] : '0;
    assign bus.alu_op       = grant_valid ? bus.req_op[5*winner +: 5] : '0;
    assign bus.alu_saturate = grant_valid ? bus.req_sat[winner] : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rr_ptr_q     <= '0;
        end else if (grant_valid) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= winner;
            rsp_result_q <= bus.alu_result;
            rsp_flags_q  <= bus.alu_flags;
            rr_ptr_q     <= next_ptr;
        end else if (bus.rsp_ready) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grants_q [NUM_REQ];
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) grants_q[i] <= '0;
            stall_q <= '0;
        end else begin
            if (grant_valid && grants_q[winner] != 16'hFFFF) begin
                grants_q[winner] <= grants_q[winner] + 16'd1;
            end
            if ((|bus.req_valid) && !grant_valid && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_grants[16*g +: 16] = grants_q[g];
    end
    assign stat_stall = stall_q;
`endif

endmodule
